// File: rtl/tt_sweep_checker.sv
// rtl/tt_sweep_checker.sv - exhaustive truth-table sweeper with per-channel golden compare
module tt_sweep_checker #(
    parameter int N_IN = 4,
    parameter int N_CH = 5,
    parameter int HOLD = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        continuous,
    input  logic                        abort,
    output logic [N_IN-1:0]             stim,
    input  logic [N_CH-1:0]             resp,
    input  logic [N_CH*(2**N_IN)-1:0]   expected,
    output logic [N_CH*(2**N_IN)-1:0]   tt,
    output logic                        tt_valid,
    output logic [N_CH-1:0]             mismatch,
    output logic                        busy,
    output logic                        done
);

    localparam int NV = 2 ** N_IN;
    localparam int TW = N_CH * NV;
    localparam logic [7:0]      HOLD_M1   = 8'(HOLD - 1);
    localparam logic [N_IN-1:0] STIM_LAST = '1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   stim_q, stim_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [TW-1:0]     work_q, work_d;
    logic [TW-1:0]     tt_q, tt_d;
    logic              tt_valid_q, tt_valid_d;
    logic [N_CH-1:0]   mismatch_q, mismatch_d;
    logic              done_q, done_d;

    // Working table with the current sample merged in, and its compare result
    logic [TW-1:0]     work_upd;
    logic [N_CH-1:0]   mm_upd;

    always_comb begin
        work_upd = work_q;
        mm_upd   = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            work_upd[ch*NV + int'(stim_q)] = resp[ch];
        end
        for (int ch = 0; ch < N_CH; ch++) begin
            mm_upd[ch] = |(work_upd[ch*NV +: NV] ^ expected[ch*NV +: NV]);
        end
    end

    always_comb begin
        state_d    = state_q;
        stim_d     = stim_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        tt_d       = tt_q;
        tt_valid_d = tt_valid_q;
        mismatch_d = mismatch_q;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d    = RUN;
                    stim_d     = '0;
                    cnt_d      = HOLD_M1;
                    tt_valid_d = 1'b0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    stim_d  = '0;
                end else if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    work_d = work_upd;
                    stim_d = stim_q + N_IN'(1);
                    cnt_d  = HOLD_M1;
                    if (stim_q == STIM_LAST) begin
                        tt_d       = work_upd;
                        mismatch_d = mm_upd;
                        tt_valid_d = 1'b1;
                        done_d     = 1'b1;
                        if (!continuous) begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            stim_q     <= '0;
            cnt_q      <= '0;
            work_q     <= '0;
            tt_q       <= '0;
            tt_valid_q <= 1'b0;
            mismatch_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            stim_q     <= stim_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            tt_q       <= tt_d;
            tt_valid_q <= tt_valid_d;
            mismatch_q <= mismatch_d;
            done_q     <= done_d;
        end
    end

    assign stim     = stim_q;
    assign tt       = tt_q;
    assign tt_valid = tt_valid_q;
    assign mismatch = mismatch_q;
    assign busy     = (state_q == RUN);
    assign done     = done_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// tb/tb_tt_sweep_checker.sv - randomized self-checking bench for tt_sweep_checker
module tb_tt_sweep_checker;

    localparam int N_IN = 4;
    localparam int N_CH = 2;
    localparam int HOLD = 2;
    localparam int NV   = 16;
    localparam int TW   = N_CH * NV;
    localparam int P    = NV * HOLD;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            continuous = 1'b0;
    logic            abort = 1'b0;
    logic [N_IN-1:0] stim;
    logic [N_CH-1:0] resp;
    logic [TW-1:0]   expected;
    logic [TW-1:0]   tt;
    logic            tt_valid;
    logic [N_CH-1:0] mismatch;
    logic            busy;
    logic            done;

    // Truth table actually realised by the emulated functions under test
    logic [TW-1:0]   applied;
    logic [TW-1:0]   prev_tt;
    logic [N_CH-1:0] prev_mm;
    int              n_checks = 0;
    int              n_errors = 0;

    tt_sweep_checker #(.N_IN(N_IN), .N_CH(N_CH), .HOLD(HOLD)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .continuous (continuous),
        .abort      (abort),
        .stim       (stim),
        .resp       (resp),
        .expected   (expected),
        .tt         (tt),
        .tt_valid   (tt_valid),
        .mismatch   (mismatch),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always_comb begin
        resp = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            resp[ch] = applied[ch*NV + int'(stim)];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N_CH-1:0] model_mm(input logic [TW-1:0] a, input logic [TW-1:0] e);
        logic [N_CH-1:0] m;
        m = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            m[ch] = (a[ch*NV +: NV] != e[ch*NV +: NV]);
        end
        return m;
    endfunction

    // Start a sweep and check every cycle k edges after the start edge.
    // passes: pass count before it stops by itself; abort_edge: edge at which abort is seen;
    // clr_at/start_at: cycles at which continuous is cleared / start is pulsed (-1 = never).
    task automatic track(input int ncyc, input int passes, input int abort_edge,
                         input int clr_at, input int start_at);
        logic [TW-1:0]   ett;
        logic [N_CH-1:0] emm;
        int              comp;
        bit              stopped;
        bit              ebusy;
        bit              edone;
        ett  = applied;
        emm  = model_mm(applied, expected);
        comp = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k <= ncyc; k++) begin
            if (k > 0) @(negedge clk);
            stopped = (abort_edge > 0) && (k >= abort_edge);
            comp = k / P;
            if (comp > passes) comp = passes;
            if (stopped && comp > (abort_edge - 1) / P) comp = (abort_edge - 1) / P;
            ebusy = !stopped && (k < passes * P);
            edone = !stopped && (k > 0) && (k % P == 0) && (k <= passes * P);
            check("stim", 64'(stim), ebusy ? 64'((k / HOLD) % NV) : 64'd0);
            check("busy", 64'(busy), 64'(ebusy));
            check("done", 64'(done), 64'(edone));
            check("tt_valid", 64'(tt_valid), 64'(comp > 0));
            check("tt", 64'(tt), 64'(comp > 0 ? ett : prev_tt));
            check("mismatch", 64'(mismatch), 64'(comp > 0 ? emm : prev_mm));
            abort = (k == abort_edge - 1);
            start = (k == start_at);
            if (k == clr_at) continuous = 1'b0;
        end
        abort = 1'b0;
        start = 1'b0;
        if (comp > 0) begin
            prev_tt = ett;
            prev_mm = emm;
        end
    endtask

    initial begin
        logic [3:0] v;
        applied  = '0;
        expected = '0;
        prev_tt  = '0;
        prev_mm  = '0;

        repeat (3) @(negedge clk);
        check("rst_stim", 64'(stim), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_tt_valid", 64'(tt_valid), 64'd0);
        check("rst_tt", 64'(tt), 64'd0);
        check("rst_mismatch", 64'(mismatch), 64'd0);
        rst_n = 1'b1;

        // start and abort together in IDLE: nothing happens
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", 64'(busy), 64'd0);
        check("start_abort_stim", 64'(stim), 64'd0);
        repeat (3) @(negedge clk);
        check("start_abort_busy_later", 64'(busy), 64'd0);

        // AND of first two variables on ch0, parity on ch1
        for (int i = 0; i < NV; i++) begin
            v = 4'(i);
            applied[i]      = v[3] & v[2];
            applied[NV + i] = ^v;
        end
        expected = {16'h6996, 16'hF000};
        track(P + 4, 1, -1, -1, -1);
        check("spec_tt", 64'(tt), 64'h6996F000);
        check("spec_mismatch", 64'(mismatch), 64'd0);

        // start during RUN must not disturb the sweep
        track(P + 4, 1, -1, -1, 7);

        // fault on ch1 at vector 5
        applied[NV + 5] = 1'b1;
        track(P + 4, 1, -1, -1, -1);
        check("fault_tt", 64'(tt), 64'h69B6F000);
        check("fault_mismatch", 64'(mismatch), 64'b10);

        // continuous, cleared mid third pass: exactly one more done
        applied  = {16'h6996, 16'hF000};
        continuous = 1'b1;
        track(3 * P + 10, 3, -1, 2 * P + 5, -1);

        // abort at vector 9 of the second pass, after a faulted first pass
        applied[3] = 1'b1;
        continuous = 1'b1;
        track(2 * P + 12, 3, P + 9 * HOLD + 1, -1, -1);
        continuous = 1'b0;
        check("abort_tt_valid", 64'(tt_valid), 64'd1);
        check("abort_mismatch", 64'(mismatch), 64'b01);

        // abort before any pass completes: tt_valid stays low, tt kept
        track(P / 2 + 6, 1, 10, -1, -1);

        // randomized tables, golden equal / one bit off / unrelated
        for (int r = 0; r < 6; r++) begin
            applied = {$urandom, $urandom};
            case (r % 3)
                0: expected = applied;
                1: expected = applied ^ (TW'(1) << $urandom_range(TW - 1, 0));
                default: expected = {$urandom, $urandom};
            endcase
            track(P + 3, 1, -1, -1, -1);
        end

        // asynchronous reset mid-sweep
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_stim", 64'(stim), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_tt_valid", 64'(tt_valid), 64'd0);
        check("arst_tt", 64'(tt), 64'd0);
        check("arst_mismatch", 64'(mismatch), 64'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        prev_tt = '0;
        prev_mm = '0;
        applied = {$urandom, $urandom};
        expected = applied;
        track(P + 3, 1, -1, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
